// File: rtl/riscv_ifu.sv
`default_nettype none
// riscv_ifu: single-outstanding instruction fetch feeding a small decode-side FIFO.
// Optional macro IFU_SEQ_EN adds a 64-bit per-instruction sequence number (ifu_seq).
module riscv_ifu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        exu_redirect,
  input  logic [31:0] exu_redirect_addr,
  input  logic        idu_rdy,
  output logic        ifu_vld,
  output logic [31:0] ifu_addr,
  output logic [31:0] ifu_data
`ifdef IFU_SEQ_EN
  ,
  output logic [63:0] ifu_seq
`endif
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0] RV      = {RESET_VECTOR[31:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt, drop_addr;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic          push, pop;

  assign redirect_pc = exu_redirect_addr & ~32'h3;
  assign ifu_vld     = (count != '0);
  assign ifu_addr    = fifo_addr[rd_ptr];
  assign ifu_data    = fifo_data[rd_ptr];
  assign pop         = ifu_vld && idu_rdy && !exu_redirect;
  assign imem_req    = (state != IDLE);
  assign imem_addr   = (state == DROP) ? drop_addr : pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (exu_redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = FETCH;
        end else if (count < DEPTH_C) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (exu_redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          push      = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = ((count + CW'(1)) < DEPTH_C) ? FETCH : IDLE;
        end
      end
      DROP: begin
        // The stale request must still complete; an ack releases us to the latest pc.
        if (exu_redirect) pc_nxt = redirect_pc;
        if (imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RV;
      drop_addr <= RV;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == FETCH && state_nxt == DROP) drop_addr <= pc;
      if (exu_redirect) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Payload storage needs no reset: entries are only visible once written.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pc;
      fifo_data[wr_ptr] <= imem_data;
    end
  end

`ifdef IFU_SEQ_EN
  logic [63:0] seq_cnt;
  logic [63:0] fifo_seq [FIFO_DEPTH];

  always_ff @(posedge clock) begin
    if (reset)     seq_cnt <= '0;
    else if (push) seq_cnt <= seq_cnt + 64'd1;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_seq[wr_ptr] <= seq_cnt;
  end

  assign ifu_seq = fifo_seq[rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_ifu.sv
`default_nettype none
// tb_riscv_ifu: directed stimulus with a queue-based reference model checked every cycle.
module tb_riscv_ifu;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        exu_redirect;
  logic [31:0] exu_redirect_addr;
  logic        idu_rdy;
  logic        ifu_vld;
  logic [31:0] ifu_addr;
  logic [31:0] ifu_data;
  logic [63:0] seq_out;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

`ifdef IFU_SEQ_EN
  logic [63:0] ifu_seq;
  assign seq_out = ifu_seq;
`else
  assign seq_out = 64'd0;
`endif

  riscv_ifu dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .exu_redirect(exu_redirect), .exu_redirect_addr(exu_redirect_addr),
    .idu_rdy(idu_rdy),
    .ifu_vld(ifu_vld), .ifu_addr(ifu_addr), .ifu_data(ifu_data)
`ifdef IFU_SEQ_EN
    , .ifu_seq(ifu_seq)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign imem_data = memfn(imem_addr);
  assign imem_ack  = ack_en & imem_req;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: an outstanding-request flag, a "stale" flag and a queue of entries.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [63:0] s;
  } ent_t;
  ent_t        q[$];
  ent_t        e;
  bit          mdl_ok = 1'b0;
  bit          m_req, m_drop, m_ack;
  logic [31:0] m_pc, m_raddr;
  logic [63:0] m_seq;
  int          m_n;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_pc = 32'h0; m_raddr = 32'h0; m_req = 1'b0; m_drop = 1'b0; m_seq = 64'd0;
      mdl_ok = 1'b1;
    end else begin
      m_ack = m_req && ack_en;
      m_n   = q.size();
      if (exu_redirect) begin
        q.delete();
        m_pc = exu_redirect_addr & ~32'h3;
        if (m_req && !m_ack) m_drop = 1'b1;
        else begin m_req = 1'b1; m_drop = 1'b0; m_raddr = m_pc; end
      end else begin
        if (q.size() != 0 && idu_rdy) void'(q.pop_front());
        if (m_ack && !m_drop) begin
          e.a = m_raddr; e.d = memfn(m_raddr); e.s = m_seq;
          q.push_back(e);
          m_seq = m_seq + 64'd1;
          m_pc  = m_pc + 32'd4;
          m_n++;
        end
        if (m_req && !m_ack) ;
        else if (m_req && m_drop) begin m_drop = 1'b0; m_raddr = m_pc; end
        else begin m_req = (m_n < DEPTH); m_raddr = m_pc; end
      end
    end
  end

  logic [31:0] log_a[$];
  logic [63:0] log_s[$];
  int          ack_cnt = 0;

  always @(negedge clock) begin
    if (mdl_ok) begin
      chk("imem_req",  64'(imem_req),  64'(m_req));
      chk("imem_addr", 64'(imem_addr), 64'(m_drop ? m_raddr : m_pc));
      chk("ifu_vld",   64'(ifu_vld),   64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("ifu_addr", 64'(ifu_addr), 64'(q[0].a));
        chk("ifu_data", 64'(ifu_data), 64'(q[0].d));
`ifdef IFU_SEQ_EN
        chk("ifu_seq", seq_out, q[0].s);
`endif
      end
    end
    if (!reset && ifu_vld && idu_rdy && !exu_redirect) begin
      log_a.push_back(ifu_addr);
      log_s.push_back(seq_out);
    end
    if (!reset && imem_ack) ack_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int k = 0;
    while (!(imem_req && imem_addr == a) && k < 20) begin step(); k++; end
    chk("wait_addr", 64'(imem_req && imem_addr == a), 64'd1);
  endtask

  task automatic ack_one();
    int k = 0;
    while (!imem_req && k < 20) begin step(); k++; end
    chk("ack_wait", 64'(imem_req), 64'd1);
    ack_en = 1'b1;
    step();
    ack_en = 1'b0;
  endtask

  initial begin
    int mark, hits;
    reset = 1'b1; ack_en = 1'b0; idu_rdy = 1'b0;
    exu_redirect = 1'b0; exu_redirect_addr = 32'h0;
    repeat (3) step();
    chk("rst_req",  64'(imem_req),  64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_vld",  64'(ifu_vld),   64'd0);

    // Streaming fetch from the reset vector
    reset = 1'b0; ack_en = 1'b1; idu_rdy = 1'b1;
    step();
    chk("c1_req",  64'(imem_req),  64'd1);
    chk("c1_addr", 64'(imem_addr), 64'd0);
    chk("c1_vld",  64'(ifu_vld),   64'd0);
    step();
    chk("c2_vld",  64'(ifu_vld),  64'd1);
    chk("c2_addr", 64'(ifu_addr), 64'd0);
    chk("c2_data", 64'(ifu_data), 64'(memfn(32'h0)));
    repeat (8) step();
    chk("s1_cnt", 64'(log_a.size() >= 3), 64'd1);
    chk("s1_a0", 64'(log_a[0]), 64'h0);
    chk("s1_a1", 64'(log_a[1]), 64'h4);
    chk("s1_a2", 64'(log_a[2]), 64'h8);

    // Back-pressure: exactly two fills, then the bus idles
    idu_rdy = 1'b0; exu_redirect = 1'b1; exu_redirect_addr = 32'h100;
    step();
    exu_redirect = 1'b0; ack_cnt = 0;
    repeat (8) step();
    chk("bp_pushes", 64'(ack_cnt),  64'd2);
    chk("bp_req",    64'(imem_req), 64'd0);
    chk("bp_vld",    64'(ifu_vld),  64'd1);
    chk("bp_head",   64'(ifu_addr), 64'h100);
    ack_cnt = 0; idu_rdy = 1'b1;
    step();
    idu_rdy = 1'b0;
    chk("bp_pop_head", 64'(ifu_addr), 64'h104);
    chk("bp_pop_req",  64'(imem_req), 64'd0);
    step();
    chk("bp_new_req",  64'(imem_req),  64'd1);
    chk("bp_new_addr", 64'(imem_addr), 64'h108);
    step();
    chk("bp_full_req", 64'(imem_req), 64'd0);
    repeat (3) step();
    chk("bp_one_ack", 64'(ack_cnt), 64'd1);

    // Redirect while a delayed request is outstanding
    idu_rdy = 1'b1; exu_redirect = 1'b1; exu_redirect_addr = 32'h10;
    step();
    exu_redirect = 1'b0; ack_en = 1'b0;
    chk("dr_addr_a", 64'(imem_addr), 64'h10);
    exu_redirect = 1'b1; exu_redirect_addr = 32'h203;
    step();
    exu_redirect = 1'b0;
    chk("dr_addr_b", 64'(imem_addr), 64'h10);
    chk("dr_vld_b",  64'(ifu_vld),   64'd0);
    step();
    chk("dr_addr_c", 64'(imem_addr), 64'h10);
    step();
    chk("dr_addr_d", 64'(imem_addr), 64'h10);
    chk("dr_vld_d",  64'(ifu_vld),   64'd0);
    ack_en = 1'b1;
    step();
    chk("dr_new_addr", 64'(imem_addr), 64'h200);
    chk("dr_vld_e",    64'(ifu_vld),   64'd0);
    step();
    chk("dr_head", 64'(ifu_addr), 64'h200);

    // Redirect coinciding with the ack for 0x8
    exu_redirect = 1'b1; exu_redirect_addr = 32'h0;
    step();
    exu_redirect = 1'b0;
    wait_addr(32'h8);
    exu_redirect = 1'b1; exu_redirect_addr = 32'h300;
    mark = log_a.size();
    step();
    exu_redirect = 1'b0;
    chk("ra_vld",  64'(ifu_vld),   64'd0);
    chk("ra_addr", 64'(imem_addr), 64'h300);
    step();
    chk("ra_head", 64'(ifu_addr), 64'h300);
    repeat (4) step();
    hits = 0;
    for (int i = mark; i < log_a.size(); i++) if (log_a[i] == 32'h8) hits++;
    chk("ra_no8",    64'(hits),        64'd0);
    chk("ra_first",  64'(log_a[mark]), 64'h300);

    // Address wrap
    exu_redirect = 1'b1; exu_redirect_addr = 32'hFFFF_FFFF;
    step();
    exu_redirect = 1'b0;
    wait_addr(32'hFFFF_FFFC);
    step();
    chk("wrap_req",  64'(imem_req),  64'd1);
    chk("wrap_addr", 64'(imem_addr), 64'h0);

    // Sequence numbering across a flushing redirect
    reset = 1'b1; ack_en = 1'b0; idu_rdy = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    log_a.delete(); log_s.delete();
    ack_one();
    step();
    idu_rdy = 1'b0;
    ack_one();
    ack_one();
    step();
    chk("sq_full_req", 64'(imem_req), 64'd0);
    chk("sq_full_vld", 64'(ifu_vld),  64'd1);
    exu_redirect = 1'b1; exu_redirect_addr = 32'h400;
    step();
    exu_redirect = 1'b0; idu_rdy = 1'b1;
    ack_one();
    ack_one();
    repeat (4) step();
    chk("sq_cnt", 64'(log_a.size()), 64'd3);
    chk("sq_a0", 64'(log_a[0]), 64'h0);
    chk("sq_a1", 64'(log_a[1]), 64'h400);
    chk("sq_a2", 64'(log_a[2]), 64'h404);
`ifdef IFU_SEQ_EN
    chk("sq_s0", log_s[0], 64'd0);
    chk("sq_s1", log_s[1], 64'd3);
    chk("sq_s2", log_s[2], 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
